// File: rtl/aes_request_arbiter.sv
// Round-robin arbiter/sequencer sharing one AES-128 decryption core between two
// clients, with a start-to-done watchdog that aborts and resets a hung core.
module aes_request_arbiter #(
  parameter int unsigned MAX_CYCLES = 128
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic         i_req0,
  input  logic         i_req1,
  input  logic [127:0] i_key0,
  input  logic [127:0] i_key1,
  input  logic [127:0] i_msg0,
  input  logic [127:0] i_msg1,
  output logic         o_gnt0,
  output logic         o_gnt1,
  output logic         o_valid0,
  output logic         o_valid1,
  output logic [127:0] o_result,
  output logic         o_err,
  output logic         o_busy,
  output logic [127:0] o_core_key,
  output logic [127:0] o_core_msg,
  output logic         o_core_start,
  output logic         o_core_reset,
  input  logic         i_core_done,
  input  logic [127:0] i_core_result
);

  localparam int unsigned TW = $clog2(MAX_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(MAX_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t        r_state, w_state;
  logic          r_pri, w_pri;
  logic          r_win, w_win;
  logic [TW-1:0] r_timer, w_timer;
  logic          r_gnt0, w_gnt0;
  logic          r_gnt1, w_gnt1;
  logic          r_valid0, w_valid0;
  logic          r_valid1, w_valid1;
  logic [127:0]  r_result, w_result;
  logic          r_err, w_err;
  logic          r_busy, w_busy;
  logic [127:0]  r_core_key, w_core_key;
  logic [127:0]  r_core_msg, w_core_msg;
  logic          r_core_start, w_core_start;
  logic          r_core_reset, w_core_reset;

  // State and output registers
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state      <= S_IDLE;
      r_pri        <= 1'b0;
      r_win        <= 1'b0;
      r_timer      <= '0;
      r_gnt0       <= 1'b0;
      r_gnt1       <= 1'b0;
      r_valid0     <= 1'b0;
      r_valid1     <= 1'b0;
      r_result     <= '0;
      r_err        <= 1'b0;
      r_busy       <= 1'b0;
      r_core_key   <= '0;
      r_core_msg   <= '0;
      r_core_start <= 1'b0;
      r_core_reset <= 1'b1;
    end else begin
      r_state      <= w_state;
      r_pri        <= w_pri;
      r_win        <= w_win;
      r_timer      <= w_timer;
      r_gnt0       <= w_gnt0;
      r_gnt1       <= w_gnt1;
      r_valid0     <= w_valid0;
      r_valid1     <= w_valid1;
      r_result     <= w_result;
      r_err        <= w_err;
      r_busy       <= w_busy;
      r_core_key   <= w_core_key;
      r_core_msg   <= w_core_msg;
      r_core_start <= w_core_start;
      r_core_reset <= w_core_reset;
    end
  end

  // Next-state and next-output logic; pulses and the core reset default low
  always_comb begin
    w_state      = r_state;
    w_pri        = r_pri;
    w_win        = r_win;
    w_timer      = r_timer;
    w_gnt0       = 1'b0;
    w_gnt1       = 1'b0;
    w_valid0     = 1'b0;
    w_valid1     = 1'b0;
    w_result     = r_result;
    w_err        = r_err;
    w_busy       = r_busy;
    w_core_key   = r_core_key;
    w_core_msg   = r_core_msg;
    w_core_start = r_core_start;
    w_core_reset = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_req0 || i_req1) begin
          w_win        = (i_req0 && i_req1) ? r_pri : i_req1;
          w_gnt0       = ~w_win;
          w_gnt1       = w_win;
          w_core_key   = w_win ? i_key1 : i_key0;
          w_core_msg   = w_win ? i_msg1 : i_msg0;
          w_core_start = 1'b1;
          w_busy       = 1'b1;
          w_timer      = '0;
          w_state      = S_RUN;
        end
      end
      S_RUN: begin
        // A done seen on the last watchdog edge still counts as success
        if (i_core_done) begin
          w_result     = i_core_result;
          w_err        = 1'b0;
          w_core_start = 1'b0;
          w_state      = S_DRAIN;
        end else if (r_timer == TIMER_LAST) begin
          w_core_start = 1'b0;
          w_core_reset = 1'b1;
          w_result     = '0;
          w_err        = 1'b1;
          w_state      = S_DRAIN;
        end else begin
          w_timer = TW'(r_timer + 1'b1);
        end
      end
      S_DRAIN: begin
        if (!i_core_done) begin
          w_valid0 = ~r_win;
          w_valid1 = r_win;
          w_busy   = 1'b0;
          w_pri    = ~r_win;
          w_state  = S_IDLE;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  assign o_gnt0       = r_gnt0;
  assign o_gnt1       = r_gnt1;
  assign o_valid0     = r_valid0;
  assign o_valid1     = r_valid1;
  assign o_result     = r_result;
  assign o_err        = r_err;
  assign o_busy       = r_busy;
  assign o_core_key   = r_core_key;
  assign o_core_msg   = r_core_msg;
  assign o_core_start = r_core_start;
  assign o_core_reset = r_core_reset;

endmodule

// File: doc/aes_request_arbiter.md
# aes_request_arbiter

Two-requester round-robin arbiter and sequencer that shares a single AES-128 decryption core between two clients, such as the Avalon register front-end and a DMA/test client. It latches the granted client's key and ciphertext and drives the core's level START/DONE handshake through completion. It returns the plaintext with a per-client valid pulse. A watchdog aborts a hung core and reports an error.

## Interface
- MAX_CYCLES, 128, watchdog limit in cycles from core start to core DONE; must be ≥ 2
- CLK  in  1  system clock; all state updates on rising edge
- RESET_N  in  1  synchronous, active-low reset
- REQ0, REQ1  in  1  request level; held by the client until its GNT pulse
- KEY0, KEY1  in  128  cipher key; sampled on the grant edge
- MSG0, MSG1  in  128  ciphertext; sampled on the grant edge
- GNT0, GNT1  out  1  one-cycle pulse: request accepted, inputs captured
- VALID0, VALID1  out  1  one-cycle pulse: RESULT/ERR valid for that client
- RESULT  out  128  plaintext; held until the next completion
- ERR  out  1  watchdog abort flag; meaningful with VALIDx; held like RESULT
- BUSY  out  1  core owned by a client
- CORE_KEY, CORE_MSG  out  128  operands to core; stable while BUSY
- CORE_START  out  1  core start level
- CORE_RESET  out  1  active-high reset to core
- CORE_DONE  in  1  core done level; stays high until START drops
- CORE_RESULT  in  128  core plaintext; valid while CORE_DONE=1

## Operation
- All outputs are registered.
- Reset values: GNTx=0, VALIDx=0, RESULT=0, ERR=0, BUSY=0, CORE_KEY=0, CORE_MSG=0, CORE_START=0, CORE_RESET=1.
- Internal state on reset: PRI=0, timer=0, state IDLE.
- CORE_RESET deasserts on the first edge with RESET_N=1, except during an abort (see RUN).
- State IDLE: at an edge with any REQ high:
  - Winner: the only requester, or PRI when both request.
  - Set GNT(winner)=1, load CORE_KEY/CORE_MSG from the winner, CORE_START=1, BUSY=1, timer=0, go to RUN.
- State RUN: GNTx returns to 0 on the next edge. At each edge:
  - CORE_DONE=1: RESULT←CORE_RESULT, ERR←0, CORE_START=0, go to DRAIN.
  - Else, timer==MAX_CYCLES−1: abort. CORE_START=0, CORE_RESET=1 for exactly one cycle, RESULT←0, ERR←1, go to DRAIN.
  - Else: timer+1. Timer width is clog2(MAX_CYCLES); it never wraps.
- State DRAIN: wait for CORE_DONE=0. At that edge:
  - VALID(winner)=1 for one cycle, BUSY=0.
  - PRI←~winner. This fixed alternation applies even if the other client is idle.
  - Go to IDLE.
- REQx during BUSY is ignored: no GNT, no capture. The client keeps REQ high and is served later.
- A REQ still high after its own GNT counts as a new request.
- KEY/MSG changes after GNT have no effect.

## Timing
- Grant latency: REQ sampled at edge E0 (IDLE) → GNT high and CORE_START high in cycle E0+1.
- Minimum turnaround: CORE_DONE seen at edge Ed → DRAIN. If CORE_DONE=0 at edge Ed+1, VALID is high in cycle Ed+2.
- The core DONE stays high one cycle after START drops. Typical VALID therefore comes 2–3 cycles after DONE first rises.
- Back-to-back: IDLE is reached in the same cycle VALID is high. A pending REQ is granted at the next edge, so GNT of the next job lands in the cycle after VALID.
- Simultaneous CORE_DONE=1 and timeout at the same edge: done wins, ERR=0.
- Watchdog boundary:
  - CORE_DONE first seen at the MAX_CYCLES-th RUN edge counts as success.
  - With no DONE, abort occurs at that edge.
- Reset mid-operation: at the first edge with RESET_N=0, all outputs take their reset values and PRI=0. No VALID is issued for the in-flight job.

## Test plan
- Single job: REQ0 with FIPS-197 key 000102…0f and ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a; core model DONE after 40 cycles → GNT0 one cycle after REQ, VALID0 with RESULT=00112233445566778899aabbccddeeff, ERR=0.
- Contention: REQ0 and REQ1 high from reset → grant order 0, 1, 0, 1 over four jobs; each VALID matches its GNT client.
- Busy block: REQ1 asserted mid-job0 → no GNT1 until VALID0; GNT1 in the cycle after VALID0.
- Watchdog with MAX_CYCLES=8 and core never asserting DONE → CORE_START drops and CORE_RESET pulses exactly once, 8 cycles after GNT; then VALID with ERR=1, RESULT=0.
- Boundary with MAX_CYCLES=8: DONE first high at the 8th RUN edge → ERR=0, correct RESULT, no CORE_RESET pulse.
- Reset mid-job: RESET_N low for one cycle during RUN → all outputs 0 except CORE_RESET=1, no VALID; next REQ1 granted normally.
